// File: rtl/fibo_sched_pkg.sv
// Shared types and helpers for the Fibonacci job scheduler and its round-robin arbiter.
package fibo_sched_pkg;

  localparam int unsigned MinReq = 2;
  localparam int unsigned MaxReq = 16;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StWait,
    StResp
  } state_t;

  function automatic int unsigned id_width(input int unsigned num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

endpackage

// File: rtl/fibo_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr_i wins, one-hot grant.
module fibo_rr_arbiter
  import fibo_sched_pkg::*;
#(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned IdW     = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IdW-1:0]     ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IdW-1:0]     gnt_id_o,
  output logic               valid_o
);

  int unsigned idx;

  always_comb begin
    gnt_o    = '0;
    gnt_id_o = '0;
    valid_o  = 1'b0;
    idx      = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = (32'(ptr_i) + k) % NUM_REQ;
      if (!valid_o && req_i[idx[IdW-1:0]]) begin
        valid_o                 = 1'b1;
        gnt_o[idx[IdW-1:0]]     = 1'b1;
        gnt_id_o                = idx[IdW-1:0];
      end
    end
  end

endmodule

// File: rtl/fibo_job_scheduler.sv
// Shares one Fibonacci engine between NUM_REQ requesters with round-robin arbitration.
// Optional WAIT-state timeout is enabled by defining FIBO_SCHED_TIMEOUT_EN.
module fibo_job_scheduler
  import fibo_sched_pkg::*;
#(
  parameter  int unsigned NUM_REQ        = 4,
  parameter  int unsigned DATA_WIDTH     = 64,
  parameter  int unsigned ORDER_WIDTH    = 16,
  parameter  int unsigned TIMEOUT_CYCLES = 1024,
  localparam int unsigned IdW            = id_width(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             reqValid,
  output logic [NUM_REQ-1:0]             reqReady,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  reqData,
  input  logic [NUM_REQ*ORDER_WIDTH-1:0] reqOrder,
  output logic                           engLoad,
  output logic [DATA_WIDTH-1:0]          engData,
  output logic [ORDER_WIDTH-1:0]         engOrder,
  input  logic [DATA_WIDTH-1:0]          engResult,
  input  logic                           engCarry,
  input  logic                           engDone,
  output logic                           rspValid,
  input  logic                           rspReady,
  output logic [IdW-1:0]                 rspId,
  output logic [DATA_WIDTH-1:0]          rspResult,
  output logic                           rspCarry,
  output logic                           rspError
);

  typedef struct packed {
    logic [IdW-1:0]        id;
    logic [DATA_WIDTH-1:0] result;
    logic                  carry;
    logic                  error;
  } rsp_t;

  if (NUM_REQ < MinReq || NUM_REQ > MaxReq || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("fibo_job_scheduler: unsupported parameter value");
  end

  state_t                 state_q;
  logic [IdW-1:0]         ptr_q;
  logic [IdW-1:0]         id_q;
  logic [DATA_WIDTH-1:0]  data_q;
  logic [ORDER_WIDTH-1:0] order_q;
  logic [NUM_REQ-1:0]     req_ready_q;
  logic                   eng_load_q;
  logic                   rsp_valid_q;
  rsp_t                   rsp_q;

  logic [NUM_REQ-1:0]     gnt;
  logic [IdW-1:0]         gnt_id;
  logic                   gnt_valid;
  logic [DATA_WIDTH-1:0]  sel_data;
  logic [ORDER_WIDTH-1:0] sel_order;
  logic [IdW-1:0]         ptr_next;
  logic                   timeout;

  fibo_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arbiter (
    .req_i    (reqValid),
    .ptr_i    (ptr_q),
    .gnt_o    (gnt),
    .gnt_id_o (gnt_id),
    .valid_o  (gnt_valid)
  );

  always_comb begin
    sel_data  = '0;
    sel_order = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sel_data  = reqData[i*DATA_WIDTH +: DATA_WIDTH];
        sel_order = reqOrder[i*ORDER_WIDTH +: ORDER_WIDTH];
      end
    end
  end

  assign ptr_next = (gnt_id == IdW'(NUM_REQ - 1)) ? '0 : gnt_id + IdW'(1);

`ifdef FIBO_SCHED_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CntW-1:0] wait_cnt_q;

  // Counts WAIT cycles; cleared whenever the FSM is elsewhere.
  always_ff @(posedge clk) begin
    if (reset || state_q != StWait) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_q + CntW'(1);
    end
  end

  assign timeout = (wait_cnt_q == CntW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      id_q        <= '0;
      data_q      <= '0;
      order_q     <= '0;
      req_ready_q <= '0;
      eng_load_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_q       <= '0;
    end else begin
      req_ready_q <= '0;
      eng_load_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (gnt_valid) begin
            req_ready_q <= gnt;
            id_q        <= gnt_id;
            ptr_q       <= ptr_next;
            if (sel_data == '0 || sel_order == '0) begin
              // Rejected job: response raised one cycle later so it never overlaps reqReady.
              rsp_q.id     <= gnt_id;
              rsp_q.result <= '0;
              rsp_q.carry  <= 1'b0;
              rsp_q.error  <= 1'b1;
              state_q      <= StResp;
            end else begin
              data_q     <= sel_data;
              order_q    <= sel_order;
              eng_load_q <= 1'b1;
              state_q    <= StLoad;
            end
          end
        end
        StLoad: state_q <= StWait;
        StWait: begin
          if (engCarry) begin
            rsp_q.id     <= id_q;
            rsp_q.result <= '1;
            rsp_q.carry  <= 1'b1;
            rsp_q.error  <= 1'b0;
            rsp_valid_q  <= 1'b1;
            state_q      <= StResp;
          end else if (engDone) begin
            rsp_q.id     <= id_q;
            rsp_q.result <= engResult;
            rsp_q.carry  <= 1'b0;
            rsp_q.error  <= 1'b0;
            rsp_valid_q  <= 1'b1;
            state_q      <= StResp;
          end else if (timeout) begin
            rsp_q.id     <= id_q;
            rsp_q.result <= '0;
            rsp_q.carry  <= 1'b0;
            rsp_q.error  <= 1'b1;
            rsp_valid_q  <= 1'b1;
            state_q      <= StResp;
          end
        end
        StResp: begin
          if (!rsp_valid_q) begin
            rsp_valid_q <= 1'b1;
          end else if (rspReady) begin
            rsp_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign reqReady  = req_ready_q;
  assign engLoad   = eng_load_q;
  assign engData   = data_q;
  assign engOrder  = order_q;
  assign rspValid  = rsp_valid_q;
  assign rspId     = rsp_q.id;
  assign rspResult = rsp_q.result;
  assign rspCarry  = rsp_q.carry;
  assign rspError  = rsp_q.error;

endmodule

// File: tb/tb_fibo_job_scheduler.sv
// Self-checking bench for fibo_job_scheduler with a behavioural Fibonacci engine and scoreboard.
module tb_fibo_job_scheduler;

  localparam int unsigned N  = 4;
  localparam int unsigned DW = 64;
  localparam int unsigned OW = 16;
  localparam int unsigned TO = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    reqValid;
  logic [N-1:0]    reqReady;
  logic [N*DW-1:0] reqData;
  logic [N*OW-1:0] reqOrder;
  logic            engLoad;
  logic [DW-1:0]   engData;
  logic [OW-1:0]   engOrder;
  logic [DW-1:0]   engResult;
  logic            engCarry = 1'b0;
  logic            engDone  = 1'b0;
  logic            rspValid;
  logic            rspReady;
  logic [1:0]      rspId;
  logic [DW-1:0]   rspResult;
  logic            rspCarry;
  logic            rspError;

  always #5 clk = ~clk;

  fibo_job_scheduler #(
    .NUM_REQ        (N),
    .DATA_WIDTH     (DW),
    .ORDER_WIDTH    (OW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .reqValid  (reqValid),
    .reqReady  (reqReady),
    .reqData   (reqData),
    .reqOrder  (reqOrder),
    .engLoad   (engLoad),
    .engData   (engData),
    .engOrder  (engOrder),
    .engResult (engResult),
    .engCarry  (engCarry),
    .engDone   (engDone),
    .rspValid  (rspValid),
    .rspReady  (rspReady),
    .rspId     (rspId),
    .rspResult (rspResult),
    .rspCarry  (rspCarry),
    .rspError  (rspError)
  );

  // Engine model: (a,b)=(0,seed), order steps of (b,a+b); done after last step, carry on overflow.
  logic [DW-1:0] ea = '0, eb = '0;
  logic [OW-1:0] ecnt = '0;
  logic [DW:0]   esum;
  logic          eng_hang = 1'b0;
  assign esum      = {1'b0, ea} + {1'b0, eb};
  assign engResult = eb;

  always @(posedge clk) begin
    if (engLoad) begin
      ea       <= '0;
      eb       <= engData;
      ecnt     <= engOrder;
      engDone  <= 1'b0;
      engCarry <= 1'b0;
    end else if (ecnt != 0 && !engCarry) begin
      ea   <= eb;
      eb   <= esum[DW-1:0];
      ecnt <= ecnt - 1'b1;
      if (esum[DW] && !eng_hang) engCarry <= 1'b1;
      else if (ecnt == 1 && !eng_hang) engDone <= 1'b1;
    end
  end

  typedef struct {
    logic [1:0]  id;
    logic [63:0] res;
    logic        carry;
    logic        err;
  } exp_t;

  typedef struct {
    int unsigned id;
    logic [63:0] data;
    logic [15:0] order;
    logic [63:0] res;
    logic        carry;
    logic        err;
    int          lat;
  } vec_t;

  exp_t        sb[$];
  int          grant_log[$];
  exp_t        slot_exp[N];
  logic [63:0] slot_data[N];
  logic [15:0] slot_order[N];
  int          want[N];
  int          acc[N];
  logic        rsp_rdy = 1'b1;
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc = 0, acc_cyc = 0, last_lat = 0, load_cnt = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit busy();
    for (int i = 0; i < N; i++) if (acc[i] < want[i]) return 1'b1;
    return sb.size() != 0;
  endfunction

  // One clock: sample on negedge (scoreboard), drive #1 after posedge.
  task automatic step();
    exp_t e;
    @(negedge clk);
    if (reqReady != '0) check("req_ready_onehot", 128'($onehot(reqReady)), 128'd1);
    if (rspValid) check("no_grant_during_rsp", 128'(reqReady), 128'd0);
    for (int i = 0; i < N; i++) begin
      if (reqValid[i] && reqReady[i]) begin
        acc[i]++;
        sb.push_back(slot_exp[i]);
        grant_log.push_back(i);
        acc_cyc = cyc;
      end
    end
    if (engLoad) load_cnt++;
    if (rspValid && rspReady) begin
      last_lat = cyc - acc_cyc;
      if (sb.size() == 0) begin
        check("unexpected_rsp", 128'(rspValid), 128'd0);
      end else begin
        e = sb.pop_front();
        check("rsp", {rspId, rspResult, rspCarry, rspError}, {e.id, e.res, e.carry, e.err});
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < N; i++) begin
      reqValid[i]            = (acc[i] < want[i]);
      reqData[i*DW +: DW]    = slot_data[i];
      reqOrder[i*OW +: OW]   = slot_order[i];
    end
    rspReady = rsp_rdy;
  endtask

  task automatic run_batch(input int max_cycles);
    int n = 0;
    while (busy() && n < max_cycles) begin
      step();
      n++;
    end
    if (busy()) check("batch_timeout", 128'(n), 128'(max_cycles + 1));
  endtask

  task automatic set_job(input int id, input logic [63:0] d, input logic [15:0] o,
                         input logic [63:0] r, input logic c, input logic er);
    slot_data[id]  = d;
    slot_order[id] = o;
    slot_exp[id]   = '{id: 2'(id), res: r, carry: c, err: er};
    want[id]       = acc[id] + 1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    sb.delete();
    for (int i = 0; i < N; i++) want[i] = acc[i];
    reqValid = '0;
  endtask

  vec_t tbl[9];
  int   exp_g[5];
  logic [67:0] cap;
  int   l0;
  int   guard;

  initial begin
    tbl[0] = '{id: 0, data: 64'd1, order: 16'd10,  res: 64'd89,    carry: 0, err: 0, lat: 12};
    tbl[1] = '{id: 1, data: 64'd5, order: 16'd1,   res: 64'd5,     carry: 0, err: 0, lat: 3};
    tbl[2] = '{id: 2, data: 64'd0, order: 16'd7,   res: 64'd0,     carry: 0, err: 1, lat: 0};
    tbl[3] = '{id: 3, data: 64'd9, order: 16'd0,   res: 64'd0,     carry: 0, err: 1, lat: 0};
    tbl[4] = '{id: 0, data: 64'd1, order: 16'd100, res: '1,        carry: 1, err: 0, lat: 0};
    tbl[5] = '{id: 1, data: 64'd3, order: 16'd5,   res: 64'd24,    carry: 0, err: 0, lat: 7};
    tbl[6] = '{id: 2, data: 64'd2, order: 16'd20,  res: 64'd21892, carry: 0, err: 0, lat: 22};
    tbl[7] = '{id: 3, data: 64'd1, order: 16'd92,
               res: 64'd12200160415121876738, carry: 0, err: 0, lat: 94};
    tbl[8] = '{id: 0, data: 64'd1, order: 16'd93,  res: '1,        carry: 1, err: 0, lat: 0};

    for (int i = 0; i < N; i++) begin
      want[i] = 0; acc[i] = 0; slot_data[i] = '0; slot_order[i] = '0;
      slot_exp[i] = '{id: 2'd0, res: 64'd0, carry: 1'b0, err: 1'b0};
    end
    reqValid = '0; reqData = '0; reqOrder = '0; rspReady = 1'b1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready_load", {reqReady, engLoad, rspValid}, '0);
    check("reset_eng", {engData, engOrder}, '0);
    check("reset_rsp", {rspId, rspResult, rspCarry, rspError}, '0);
    reset = 1'b0;

    // Table-driven single jobs
    foreach (tbl[k]) begin
      set_job(tbl[k].id, tbl[k].data, tbl[k].order, tbl[k].res, tbl[k].carry, tbl[k].err);
      l0 = load_cnt;
      run_batch(400);
      check("eng_load_pulses", 128'(load_cnt - l0), tbl[k].err ? 128'd0 : 128'd1);
      if (tbl[k].lat != 0) check("latency", 128'(last_lat), 128'(tbl[k].lat));
    end

    // Round-robin: all requesters valid, requester 0 twice
    do_reset();
    grant_log.delete();
    exp_g[0] = 0; exp_g[1] = 1; exp_g[2] = 2; exp_g[3] = 3; exp_g[4] = 0;
    for (int i = 0; i < N; i++) set_job(i, 64'(i + 1), 16'd2, 64'(2 * (i + 1)), 1'b0, 1'b0);
    want[0] = acc[0] + 2;
    run_batch(300);
    check("rr_grant_count", 128'(grant_log.size()), 128'd5);
    for (int k = 0; k < 5 && k < grant_log.size(); k++)
      check("rr_order", 128'(grant_log[k]), 128'(exp_g[k]));

    // Backpressure: response held for 20 cycles, no new grant meanwhile
    rsp_rdy = 1'b0;
    set_job(1, 64'd3, 16'd5, 64'd24, 1'b0, 1'b0);
    set_job(2, 64'd1, 16'd3, 64'd3, 1'b0, 1'b0);
    guard = 0;
    while (!rspValid && guard < 50) begin step(); guard++; end
    check("hold_rsp_seen", 128'(rspValid), 128'd1);
    cap = {rspId, rspResult, rspCarry, rspError};
    check("hold_first_fields", 128'(cap), {2'd1, 64'd24, 1'b0, 1'b0});
    for (int k = 0; k < 20; k++) begin
      step();
      check("hold_stable", {rspValid, rspId, rspResult, rspCarry, rspError}, {1'b1, cap});
      check("hold_no_ready", 128'(reqReady), 128'd0);
    end
    rsp_rdy = 1'b1;
    run_batch(200);

    // Reset while the engine is busy
    set_job(2, 64'd1, 16'd50, 64'd0, 1'b0, 1'b0);
    guard = 0;
    while (!engLoad && guard < 20) begin step(); guard++; end
    step();
    step();
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("midreset_ready_load", {reqReady, engLoad, rspValid}, '0);
    check("midreset_eng", {engData, engOrder}, '0);
    check("midreset_rsp", {rspId, rspResult, rspCarry, rspError}, '0);
    reset = 1'b0;
    sb.delete();
    for (int i = 0; i < N; i++) want[i] = acc[i];
    set_job(3, 64'd2, 16'd20, 64'd21892, 1'b0, 1'b0);
    run_batch(200);
    check("post_reset_latency", 128'(last_lat), 128'd22);

`ifdef FIBO_SCHED_TIMEOUT_EN
    eng_hang = 1'b1;
    set_job(0, 64'd1, 16'd5, 64'd0, 1'b0, 1'b1);
    run_batch(200);
    check("timeout_latency", 128'(last_lat), 128'(TO + 1));
    eng_hang = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
